// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited requests to in-order imem,
// a small FIFO toward ID, redirect flush with stale-response discard.
module fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        halted
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } entry_t;

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_discard;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic          r_halted;
   logic          r_seen;

   logic          w_push;
   logic          w_pop;
   logic [CW:0]   w_credit;
   logic [CW-1:0] w_out_nxt;
   logic [31:0]   w_redir_pc;

   assign w_credit   = {1'b0, r_count} + {1'b0, r_out};
   assign w_redir_pc = {redirect_pc[31:2], 2'b00};

   assign imem_req  = !reset && !redirect && !r_halted
                      && (w_credit < (CW+1)'(DEPTH));
   assign imem_addr = r_fetch_pc;

   assign w_push = !reset && !redirect && imem_rvalid
                   && (r_discard == '0);
   assign w_pop  = instr_valid && !id_stall && !redirect;

   always_comb begin
      w_out_nxt = r_out;
      if (imem_req && !imem_rvalid && r_out != CW'(DEPTH))
         w_out_nxt = r_out + CW'(1);
      else if (!imem_req && imem_rvalid && r_out != '0)
         w_out_nxt = r_out - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_out      <= '0;
         r_discard  <= '0;
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_halted   <= 1'b0;
         r_seen     <= 1'b0;
      end else begin
         r_out <= w_out_nxt;
         if (redirect) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_halted   <= 1'b0;
            // everything still in flight belongs to the old path
            r_discard  <= (imem_rvalid && r_out != '0)
                          ? r_out - CW'(1) : r_out;
         end else begin
            if (imem_req)
               r_fetch_pc <= r_fetch_pc + 32'd4;
            if (imem_rvalid && r_discard != '0)
               r_discard <= r_discard - CW'(1);
            if (w_push) begin
               r_wptr    <= r_wptr + AW'(1);
               r_resp_pc <= r_resp_pc + 32'd4;
               r_seen    <= 1'b1;
               if (imem_rdata == HALT_WORD)
                  r_halted <= 1'b1;
            end
            if (w_pop)
               r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= '{instr: imem_rdata, addr: r_resp_pc};
   end

   assign instr_valid = (r_count != '0);
   assign instr       = r_seen ? r_mem[r_rptr].instr : '0;
   assign pc_plus4    = r_seen ? r_mem[r_rptr].addr + 32'd4 : '0;
   assign halted      = r_halted;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(w_push && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Random-stimulus bench: imem model with in-order variable latency,
// epoch-tagged reference model and scoreboard on the ID side.
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hffffffff;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_plus4;
   logic        halted;

   fetch_queue #(
      .DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_WORD(HALT)
   ) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_stall(id_stall), .redirect(redirect),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr),
      .pc_plus4(pc_plus4), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   req_t        pend[$];
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          last_due = 0;
   logic [31:0] nxt_pc = 32'h0;
   bit          m_halt = 1'b0;
   bit          after_rst = 1'b0;
   logic [31:0] halt_addr = 32'hdead0000;
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          stall_pct = 0;
   int          redir_pct = 0;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a == halt_addr) ? HALT : a;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h cycle %0d",
                  name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(4))
         0:       t = 32'h100;
         1:       t = 32'h103;
         2:       t = 32'h40;
         3:       t = 32'hfffffff8;
         default: t = $urandom & 32'h0000fffe;
      endcase
      return t;
   endfunction

   task automatic step(bit rst);
      bit   exp_req;
      bit   resp;
      req_t r;
      int   due;
      @(negedge clk);
      cyc++;
      reset       = rst;
      redirect    = !rst && (int'($urandom_range(99)) < redir_pct);
      redirect_pc = pick_target();
      id_stall    = int'($urandom_range(99)) < stall_pct;
      resp        = !rst && pend.size() > 0 && pend[0].due <= cyc;
      imem_rvalid = resp;
      imem_rdata  = resp ? mem_word(pend[0].addr) : $urandom;
      #1;
      exp_req = !rst && !redirect && !m_halt
                && (sb.size() + pend.size() < DEPTH);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req)
         check("imem_addr", imem_addr, nxt_pc);
      check("instr_valid", 32'(instr_valid), 32'(sb.size() > 0));
      check("halted", 32'(halted), 32'(m_halt));
      if (after_rst) begin
         check("rst_instr", instr, 32'h0);
         check("rst_pc_plus4", pc_plus4, 32'h0);
      end
      after_rst = rst;
      if (rst) begin
         pend.delete();
         sb.delete();
         nxt_pc   = 32'h0;
         m_halt   = 1'b0;
         last_due = cyc;
         return;
      end
      if (resp)
         r = pend.pop_front();
      if (redirect) begin
         sb.delete();
         epoch++;
         m_halt = 1'b0;
         nxt_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (resp && r.epoch == epoch) begin
            sb.push_back('{instr: mem_word(r.addr), pc4: r.addr + 32'd4});
            if (mem_word(r.addr) == HALT)
               m_halt = 1'b1;
         end
         if (exp_req) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due)
               due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: nxt_pc, epoch: epoch, due: due});
            nxt_pc = nxt_pc + 32'd4;
         end
      end
   endtask

   task automatic run(int n);
      repeat (n) step(1'b0);
   endtask

   task automatic knobs(int lo, int hi, int st, int rd);
      lat_lo    = lo;
      lat_hi    = hi;
      stall_pct = st;
      redir_pct = rd;
   endtask

   // ID-side monitor: consumes the scoreboard on every real pop
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && !redirect && instr_valid && !id_stall) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty got pc_plus4 %h want none cycle %0d",
                        pc_plus4, cyc);
            end else begin
               e = sb.pop_front();
               check("instr", instr, e.instr);
               check("pc_plus4", pc_plus4, e.pc4);
            end
         end
      end
   end

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_stall    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;

      knobs(1, 1, 0, 0);
      repeat (2) step(1'b1);
      run(40);

      knobs(1, 2, 70, 0);
      run(80);

      knobs(3, 3, 20, 15);
      run(120);

      knobs(1, 5, 40, 8);
      run(300);

      halt_addr = 32'h8;
      knobs(1, 3, 30, 0);
      step(1'b1);
      run(40);
      knobs(1, 3, 30, 10);
      run(120);

      halt_addr = 32'hdead0000;
      knobs(1, 4, 30, 6);
      for (int k = 0; k < 5; k++) begin
         run(30 + int'($urandom_range(20)));
         step(1'b1);
      end
      run(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
